demux_32_buf: RTL
=================

DEMUX_32_BUF -- requirements
Module: demux_32_buf

Interface
REQ-001 Parameter DATA_W, default 32, data path width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output queue; legal values 2 or 4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers a beat.
REQ-006 in_ready  output  1  block accepts the offered beat.
REQ-007 in_select  input  1  destination of the beat: 0 routes to port 0, 1 routes to port 1.
REQ-008 in_data  input  DATA_W  beat payload.
REQ-009 out0_valid and out1_valid  output  1  port holds a beat.
REQ-010 out0_ready and out1_ready  input  1  downstream consumes the beat.
REQ-011 out0_data and out1_data  output  DATA_W  head-of-queue payload.

Function
REQ-012 A beat SHALL transfer on a rising edge where in_valid and in_ready are both 1. in_select and in_data SHALL be sampled only on that edge.
REQ-013 in_ready SHALL be combinational and equal to "queue selected by the current in_select is not full". It SHALL NOT depend on in_valid.
REQ-014 Each port SHALL own an independent FIFO of DEPTH entries. A full or stalled port SHALL NOT block beats routed to the other port.
REQ-015 Latency SHALL be 1 cycle: a beat accepted at edge N appears on its port's outputs after edge N. There is no combinational in-to-out path.
REQ-016 Order SHALL be preserved per port. No ordering is guaranteed across the two ports.
REQ-017 A port SHALL pop on an edge where outK_valid and outK_ready are both 1. outK_data SHALL be the oldest entry and SHALL remain stable while valid and not ready.
REQ-018 Push and pop on the same port in the same edge SHALL keep the occupancy unchanged. This includes occupancy 1, where the new beat becomes the head.
REQ-019 When a port is full, in_ready SHALL be 0 for that select, even if the same port pops that cycle. No full-queue bypass is provided.
REQ-020 The read and write pointers SHALL wrap modulo DEPTH. Occupancy SHALL range 0..DEPTH. Full SHALL be occupancy == DEPTH and empty SHALL be occupancy == 0.
REQ-021 If in_select changes while in_valid=1 and in_ready=0, in_ready SHALL re-evaluate against the new select. No beat is lost or duplicated.
REQ-022 outK_valid SHALL be 0 exactly when port K is empty.

Reset
REQ-023 On rst_n=0, all of the following SHALL clear immediately and asynchronously: every pointer and occupancy count becomes 0, out0_valid and out1_valid become 0, out0_data and out1_data become 0, and counters (if present) become 0.
REQ-024 Reset asserted mid-operation SHALL discard all queued beats. After release, in_ready SHALL be 1.
REQ-025 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro DEMUX_32_BUF_COUNT_EN defined: the block SHALL add outputs cnt0 and cnt1, each 16 bits. Each counts accepted pushes to its port, increments by 1 per push, and wraps 0xFFFF to 0x0000.
REQ-027 Macro DEMUX_32_BUF_COUNT_EN undefined: cnt0, cnt1 and their registers SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-028 Package mips_pkg SHALL hold the DATA_W default constant (32) and the counter width constant (16).
REQ-029 One sub-module, fifo_32, SHALL implement one per-port queue with push/pop/full/empty. demux_32_buf SHALL instantiate it twice and add only the routing and ready logic.

Verification
REQ-030 Reset then a single beat: after reset, in_valid=1, in_select=0, in_data=32'd10, out0_ready=0. Expected: in_ready=1, and after the edge out0_valid=1, out0_data=10, out1_valid=0.
REQ-031 Fill and stall: push 10 and 20 to port 0 with out0_ready=0. Expected: in_ready=0 for select 0 and 1 for select 1. A beat of 55 to port 1 is accepted, and out1_data=55 next cycle.
REQ-032 Ordering: push 1, 2, 3, 4 to port 1 with out1_ready=1 throughout. Expected: out1_data sequence 1, 2, 3, 4, with each value valid exactly one cycle.
REQ-033 Simultaneous push/pop at occupancy 1: port 0 holds 7; push 8 and pop in the same edge. Expected: occupancy stays 1 and out0_data=8.
REQ-034 Reset mid-stream: with 2 beats queued on each port, pulse rst_n low between edges. Expected: valids drop to 0 at once, in_ready=1 after release, and no stale data appears.
REQ-035 With DEMUX_32_BUF_COUNT_EN: preload cnt1 to 0xFFFF via 65535 pushes, then push once more. Expected: cnt1=0 and cnt0 unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared constants and helpers for the demux_32_buf slice.
//   DATA_W_DEF : default payload width (32 bits)
//   CNT_W      : width of the optional per-port push counters (16 bits)
//   ptr_w()    : pointer width needed to address a queue of the given depth
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

  // Queue depths are restricted to 2 or 4, so pointers are 1 or 2 bits and
  // wrap naturally modulo DEPTH.
  function automatic int ptr_w(input int depth);
    if (depth > 2) begin
      return 2;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/demux_32_buf_fifo_32.sv
// fifo_32 -- one per-port queue of DEPTH entries with 1-cycle write latency.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and payload (ignored when full)
//   pop               : remove the head entry (ignored when empty)
//   full, empty       : occupancy == DEPTH / occupancy == 0
//   head_data         : oldest entry, straight from the storage registers
module fifo_32
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     occ_r;
  logic              push_s;
  logic              pop_s;

  assign full      = (occ_r == CW'(DEPTH));
  assign empty     = (occ_r == {CW{1'b0}});
  assign push_s    = push & ~full;
  assign pop_s     = pop & ~empty;
  assign head_data = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; storage clears on reset so the head
  // reads as zero until something is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      // Simultaneous push and pop leaves occupancy unchanged; at occupancy 1
      // the new entry becomes the head because rd_ptr advances onto it.
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   occ_r <= occ_r - {{(CW-1){1'b0}}, 1'b1};
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/demux_32_buf.sv
// demux_32_buf -- routes a valid/ready stream to one of two buffered ports.
// Each port owns an independent fifo_32, so a stalled port never blocks the
// other. Accepted beats appear on their port one cycle later.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid, in_ready             : upstream handshake (in_ready combinational
//                                    from in_select and the selected queue)
//   in_select, in_data             : destination port and payload
//   outK_valid, outK_ready, outK_data : per-port downstream handshake, K=0,1
//   cnt0, cnt1                     : 16-bit wrapping push counters, present
//                                    only when DEMUX_32_BUF_COUNT_EN is defined
module demux_32_buf
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_select,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
`ifdef DEMUX_32_BUF_COUNT_EN
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
`endif
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data
);

  logic full0_s, full1_s;
  logic empty0_s, empty1_s;
  logic in_ready_s;
  logic push0_s, push1_s;
  logic pop0_s, pop1_s;

  // No full-queue bypass: a full port refuses beats even if it pops this edge.
  assign in_ready_s = in_select ? ~full1_s : ~full0_s;
  assign in_ready   = in_ready_s;
  assign push0_s    = in_valid & in_ready_s & ~in_select;
  assign push1_s    = in_valid & in_ready_s &  in_select;
  assign pop0_s     = ~empty0_s & out0_ready;
  assign pop1_s     = ~empty1_s & out1_ready;
  assign out0_valid = ~empty0_s;
  assign out1_valid = ~empty1_s;

  fifo_32 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0_s),
    .push_data (in_data),
    .pop       (pop0_s),
    .full      (full0_s),
    .empty     (empty0_s),
    .head_data (out0_data)
  );

  fifo_32 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1_s),
    .push_data (in_data),
    .pop       (pop1_s),
    .full      (full1_s),
    .empty     (empty1_s),
    .head_data (out1_data)
  );

`ifdef DEMUX_32_BUF_COUNT_EN
  logic [CNT_W-1:0] cnt0_r, cnt1_r;

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;

  // Accepted-push counters, one per port, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (push0_s) begin
        cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (push1_s) begin
        cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule
